// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// master: the controller (drives strobes, reads op/funct/irq_req).
// slave : the datapath (drives op/funct/irq_req, reads strobes).
interface mips_multicycle_ctrl_if;
  // Instruction fields and interrupt request from the datapath.
  logic [5:0] op;
  logic [5:0] funct;
  logic       irq_req;

  // Datapath control strobes.
  logic [1:0] aluControl;
  logic [1:0] aluSrcB;
  logic       ALUSrcA;
  logic       PCSource;
  logic       PCWrite;
  logic       isBranch;
  logic       lorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       isInterrupted;
  logic       irq_ack;

  modport master (
    input  op, funct, irq_req,
    output aluControl, aluSrcB, ALUSrcA, PCSource, PCWrite, isBranch,
    output lorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
    output isInterrupted, irq_ack
  );

  modport slave (
    output op, funct, irq_req,
    input  aluControl, aluSrcB, ALUSrcA, PCSource, PCWrite, isBranch,
    input  lorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
    input  isInterrupted, irq_ack
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath.
// Decodes op/funct, sequences every datapath strobe, traps unsupported
// instructions into HALT and counts retired instructions.
// Optional interrupt entry is compiled in with the macro IRQ_SUPPORT_EN;
// without it isInterrupted/irq_ack are tied low and irq_req is ignored.
// Handshake: there is no valid/ready pair on this bus; the datapath keeps
// op/funct stable from DECODE until the instruction returns to FETCH, and
// each strobe is a level that is meaningful only in the cycle it is high.
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_multicycle_ctrl_if.master bus,
  output logic                   halted,
  output logic [3:0]             state_o,
  output logic [CNT_W-1:0]       retired
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire_c;
  logic             irq_take_c;
  logic             rfunct_ok_c;

  // Only add/sub/and/or are implemented among the R-type functions.
  assign rfunct_ok_c = (bus.funct == FN_ADD) || (bus.funct == FN_SUB) ||
                       (bus.funct == FN_AND) || (bus.funct == FN_OR);

  // An instruction retires on the edge that leaves its last state.
  assign retire_c = (state_q == S_MEMWB)  || (state_q == S_MEMWR)  ||
                    (state_q == S_ALUWB)  || (state_q == S_BRANCH) ||
                    (state_q == S_ADDIWB);

  assign retired_d = retire_c ? (retired_q + CNT_W'(1)) : retired_q;

`ifdef IRQ_SUPPORT_EN
  logic pending_q, pending_d;

  // The pending flag is consumed only in FETCH, so an interrupt never
  // splits an instruction; the flag cannot arm once the core is halted.
  assign irq_take_c = (state_q == S_FETCH) && pending_q;
  assign pending_d  = irq_take_c ? 1'b0
                                 : (pending_q || (bus.irq_req && (state_q != S_HALT)));
`else
  logic unused_irq_req;

  assign irq_take_c     = 1'b0;
  assign unused_irq_req = bus.irq_req;
`endif

  // Next-state decode; unused encodings fall into HALT.
  always_comb begin
    state_d = S_HALT;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = rfunct_ok_c ? S_EXEC : S_HALT;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_HALT;
        endcase
      end
      // op is still the lw/sw that got us here because IRWrite is low.
      S_MEMADR: state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  // State, retired counter and interrupt pending flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
`ifdef IRQ_SUPPORT_EN
      pending_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
`ifdef IRQ_SUPPORT_EN
      pending_q <= pending_d;
`endif
    end
  end

  // Moore output decode: strobes depend only on the state, except the
  // ALU operation in EXEC which follows funct.
  always_comb begin
    bus.aluControl    = ALU_ADD;
    bus.aluSrcB       = SRCB_B;
    bus.ALUSrcA       = 1'b0;
    bus.PCSource      = 1'b0;
    bus.PCWrite       = 1'b0;
    bus.isBranch      = 1'b0;
    bus.lorD          = 1'b0;
    bus.MemWrite      = 1'b0;
    bus.IRWrite       = 1'b0;
    bus.RegWrite      = 1'b0;
    bus.RegDst        = 1'b0;
    bus.MemtoReg      = 1'b0;
    bus.isInterrupted = 1'b0;
    bus.irq_ack       = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.IRWrite       = 1'b1;
        bus.aluSrcB       = SRCB_FOUR;
        bus.PCWrite       = 1'b1;
        bus.isInterrupted = irq_take_c;
        bus.irq_ack       = irq_take_c;
      end
      S_DECODE: begin
        bus.aluSrcB = SRCB_IMMSH;
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.aluSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        bus.lorD = 1'b1;
      end
      S_MEMWB: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
      end
      S_MEMWR: begin
        bus.lorD     = 1'b1;
        bus.MemWrite = 1'b1;
      end
      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.aluSrcB = SRCB_B;
        case (bus.funct)
          FN_SUB:  bus.aluControl = ALU_SUB;
          FN_AND:  bus.aluControl = ALU_AND;
          FN_OR:   bus.aluControl = ALU_OR;
          default: bus.aluControl = ALU_ADD;
        endcase
      end
      S_ALUWB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA    = 1'b1;
        bus.aluSrcB    = SRCB_B;
        bus.aluControl = ALU_SUB;
        bus.isBranch   = 1'b1;
        bus.PCSource   = 1'b1;
      end
      S_ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.aluSrcB = SRCB_IMM;
      end
      S_ADDIWB: begin
        bus.RegWrite = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign halted  = (state_q == S_HALT);
  assign state_o = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl. Expected state/strobe vectors are
// queued when an instruction is set up and compared cycle by cycle.
module tb_mips_multicycle_ctrl;

`ifdef IRQ_SUPPORT_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        halted;
  logic [3:0]  state_o;
  logic [31:0] retired;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl #(.CNT_W(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .halted  (halted),
    .state_o (state_o),
    .retired (retired)
  );

  // Clock/reset block.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  int n_cmp  = 0;
  int n_fail = 0;
  logic [20:0] exp_q[$];

  // Observed strobes, packed in the same order as exp_vec.
  logic [16:0] obs_vec;
  assign obs_vec = {bus.aluControl, bus.aluSrcB, bus.ALUSrcA, bus.PCSource,
                    bus.PCWrite, bus.isBranch, bus.lorD, bus.MemWrite,
                    bus.IRWrite, bus.RegWrite, bus.RegDst, bus.MemtoReg,
                    bus.isInterrupted, bus.irq_ack, halted};

  // Reference table: expected {state, strobes} for a state.
  function automatic logic [20:0] exp_vec(input int st, input logic [5:0] fn, input bit irq);
    logic [1:0] alu_c, srcb;
    logic srca, pcsrc, pcw, br, lord, mw, irw, rw, rd, m2r, intr, ack, hlt;
    alu_c = 2'b00; srcb = 2'b00;
    {srca, pcsrc, pcw, br, lord, mw, irw, rw, rd, m2r, intr, ack, hlt} = '0;
    case (st)
      1:  begin irw = 1; srcb = 2'b01; pcw = 1; intr = irq; ack = irq; end
      2:  srcb = 2'b11;
      3:  begin srca = 1; srcb = 2'b10; end
      4:  lord = 1;
      5:  begin m2r = 1; rw = 1; end
      6:  begin lord = 1; mw = 1; end
      7:  begin
            srca = 1;
            if (fn == 6'b100010) alu_c = 2'b01;
            else if (fn == 6'b100100) alu_c = 2'b10;
            else if (fn == 6'b100101) alu_c = 2'b11;
          end
      8:  begin rd = 1; rw = 1; end
      9:  begin srca = 1; alu_c = 2'b01; br = 1; pcsrc = 1; end
      10: begin srca = 1; srcb = 2'b10; end
      11: rw = 1;
      12: hlt = 1;
      default: ;
    endcase
    return {4'(st), alu_c, srcb, srca, pcsrc, pcw, br, lord, mw, irw, rw, rd, m2r, intr, ack, hlt};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic push(input int st, input bit irq = 1'b0);
    exp_q.push_back(exp_vec(st, bus.funct, irq));
  endtask

  // Pop one expected vector per cycle and compare on the falling edge.
  task automatic drain();
    logic [20:0] e;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check("state", 32'(state_o), 32'(e[20:17]));
      check($sformatf("strobes_s%0d", e[20:17]), 32'(obs_vec), 32'(e[16:0]));
    end
  endtask

  logic [5:0] fn_list[3];

  initial begin
    reset       = 1'b0;
    bus.op      = 6'b100011;
    bus.funct   = 6'b100000;
    bus.irq_req = 1'b0;
    #1 reset = 1'b1;

    // Reset state.
    @(negedge clk);
    check("reset_state", 32'(state_o), 32'd0);
    check("reset_strobes", 32'(obs_vec), 32'd0);
    check("reset_retired", retired, 32'd0);
    reset = 1'b0;
    check("idle_state", 32'(state_o), 32'd0);

    // lw: 0,1,2,3,4,5,1
    push(1); push(2); push(3); push(4); push(5);
    drain();
    check("lw_retired_before", retired, 32'd0);
    push(1);
    drain();
    check("lw_retired", retired, 32'd1);

    // sw
    bus.op = 6'b101011;
    push(2); push(3); push(6); push(1);
    drain();
    check("sw_retired", retired, 32'd2);

    // R-type sub
    bus.op = 6'b000000; bus.funct = 6'b100010;
    push(2); push(7); push(8); push(1);
    drain();
    check("rsub_retired", retired, 32'd3);

    // R-type add, and, or
    fn_list[0] = 6'b100000; fn_list[1] = 6'b100100; fn_list[2] = 6'b100101;
    for (int i = 0; i < 3; i++) begin
      bus.funct = fn_list[i];
      push(2); push(7); push(8); push(1);
      drain();
    end
    check("rall_retired", retired, 32'd6);

    // addi
    bus.op = 6'b001000;
    push(2); push(10); push(11); push(1);
    drain();
    check("addi_retired", retired, 32'd7);

    // beq
    bus.op = 6'b000100;
    push(2); push(9); push(1);
    drain();
    check("beq_retired", retired, 32'd8);

    // Interrupt pulsed during ALUWB, taken in the following FETCH only.
    bus.op = 6'b000000; bus.funct = 6'b100000;
    push(2); push(7); push(8);
    drain();
    bus.irq_req = 1'b1;
    push(1, IRQ_EN);
    drain();
    bus.irq_req = 1'b0;
    check("irq_retired", retired, 32'd9);
    bus.op = 6'b001000;
    push(2); push(10); push(11); push(1);
    drain();
    check("post_irq_retired", retired, 32'd10);

    // Reset asserted in MEMWR drops MemWrite without a clock edge.
    bus.op = 6'b101011;
    push(2); push(3); push(6);
    drain();
    #1 reset = 1'b1;
    #1;
    check("rst_memwrite", 32'(bus.MemWrite), 32'd0);
    check("rst_mid_strobes", 32'(obs_vec), 32'd0);
    check("rst_mid_state", 32'(state_o), 32'd0);
    check("rst_mid_retired", retired, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // beq then illegal op: HALT holds, irq ignored, retired frozen.
    bus.op = 6'b000100;
    push(1); push(2); push(9); push(1);
    drain();
    check("beq2_retired", retired, 32'd1);
    bus.op = 6'b111111;
    bus.irq_req = 1'b1;
    push(2);
    for (int i = 0; i < 10; i++) push(12);
    drain();
    check("halt_op_retired", retired, 32'd1);
    check("halt_op_halted", 32'(halted), 32'd1);

    // Reset while irq_req held: reset wins, the flag is armed again only
    // on the IDLE->FETCH edge. Then an illegal R-type funct halts.
    reset = 1'b1;
    bus.op = 6'b000000; bus.funct = 6'b101010;
    @(negedge clk);
    check("rst_irq_strobes", 32'(obs_vec), 32'd0);
    reset = 1'b0;
    push(1, IRQ_EN); push(2); push(12); push(12); push(12);
    drain();
    bus.irq_req = 1'b0;
    check("halt_fn_retired", retired, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore control FSM that sequences the multicycle MIPS datapath.
- Decodes `op`/`funct` from the datapath's instruction register.
- Drives every datapath control strobe.
- Also handles interrupt entry (`isInterrupted`), traps illegal opcodes into a halt state, and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  6  opcode from the datapath instruction register; valid from DECODE onward.
- funct  in  6  funct field from the datapath; valid from DECODE onward.
- irq_req  in  1  level-sensitive interrupt request.
- aluControl  out  2  00 add, 01 sub, 10 and, 11 or.
- aluSrcB  out  2  00 B register, 01 constant 4, 10 signImm, 11 signImm<<2.
- ALUSrcA  out  1  0 PC, 1 A register.
- PCSource  out  1  0 aluResult, 1 ALUOut.
- PCWrite, isBranch, lorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg  out  1 each  datapath strobes.
- isInterrupted  out  1  forces the PC path to the interrupt vector.
- irq_ack  out  1  one-cycle pulse when an interrupt is taken.
- halted  out  1  set in HALT state.
- state_o  out  4  current state encoding, for debug.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- All outputs are decoded combinationally from the state register. `aluControl` in EXEC is the only output that also depends on `funct`.
- Any strobe not listed for a state is 0.
- Reset: state=IDLE(0), `retired`=0, irq pending=0. All outputs read 0 while reset is high.
- States, their outputs, and next state:
  - IDLE(0): all 0 -> FETCH.
  - FETCH(1): lorD=0, IRWrite=1, ALUSrcA=0, aluSrcB=01, add, PCSource=0, PCWrite=1 -> DECODE.
  - DECODE(2): ALUSrcA=0, aluSrcB=11, add. Next state by op:
    - 100011 (lw) or 101011 (sw) -> MEMADR.
    - 000000 (R-type) -> EXEC, but only for funct 100000/100010/100100/100101; any other funct -> HALT.
    - 000100 (beq) -> BRANCH.
    - 001000 (addi) -> ADDIEX.
    - any other op -> HALT.
  - MEMADR(3): ALUSrcA=1, aluSrcB=10, add -> MEMRD if lw, MEMWR if sw. op is held stable by the datapath since IRWrite=0.
  - MEMRD(4): lorD=1 -> MEMWB.
  - MEMWB(5): RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
  - MEMWR(6): lorD=1, MemWrite=1 -> FETCH.
  - EXEC(7): ALUSrcA=1, aluSrcB=00; aluControl from funct: 100000->00, 100010->01, 100100->10, 100101->11. -> ALUWB.
  - ALUWB(8): RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
  - BRANCH(9): ALUSrcA=1, aluSrcB=00, sub, isBranch=1, PCSource=1 -> FETCH.
  - ADDIEX(10): ALUSrcA=1, aluSrcB=10, add -> ADDIWB.
  - ADDIWB(11): RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
  - HALT(12): all strobes 0, halted=1. Stays in HALT until reset.
- Instruction latency in cycles, FETCH to last state: lw 5, sw 4, R 4, addi 4, beq 3.
- `retired` increments by 1 on the clock edge leaving MEMWB, MEMWR, ALUWB, BRANCH or ADDIWB. It wraps modulo 2^CNT_W.
- `retired` does not increment for HALT or for interrupt entry.
- Reset asserted mid-instruction: immediate return to IDLE. No strobe may remain asserted.
- `state_o` reports the encodings above; unused codes 13-15 go to HALT.

Optional Feature:
- Macro IRQ_SUPPORT_EN.
- Defined:
  - irq pending flag sets whenever irq_req=1 and the controller is not in HALT.
  - In FETCH with pending=1: isInterrupted=1 and irq_ack=1 for that cycle, so the fetch uses the interrupt vector. Pending clears on that edge.
  - The pending flag is sampled only at FETCH entry, never mid-instruction.
  - irq_req held high re-arms pending and is taken again at the next FETCH.
  - Simultaneous irq_req and reset: reset wins, pending=0.
- Undefined: isInterrupted and irq_ack are tied to 0, irq_req is ignored, and no pending register exists.

Test Plan:
- Reset released, op=100011 -> states 0,1,2,3,4,5,1. MemtoReg=1 and RegWrite=1 only in state 5. `retired` 0->1 after state 5.
- R-type op=000000, funct=100010 -> EXEC asserts aluControl=01, aluSrcB=00, ALUSrcA=1. ALUWB asserts RegDst=1. Total 4 cycles.
- beq op=000100 -> DECODE aluSrcB=11, then BRANCH with isBranch=1, PCSource=1, aluControl=01, then FETCH. `retired` +1.
- Illegal op=111111 (and R-type funct=101010) -> HALT after DECODE, halted=1, all strobes 0 for 10 cycles. `retired` unchanged until reset.
- IRQ_SUPPORT_EN defined, irq_req pulsed during ALUWB -> next FETCH shows isInterrupted=1 and irq_ack=1 for exactly 1 cycle. With the macro undefined, both stay 0.
- Reset asserted in MEMWR with MemWrite=1 -> MemWrite drops to 0 without a clock edge. State=0, `retired`=0.
